operand_entry: RTL and testbench
================================

// Module: operand_entry
// PURPOSE
//   Upstream input stage for the calculator datapath on the DE2 board.
//   - Debounces two raw active-low push-buttons (NEXT, CLR).
//   - Steps the user through loading operand a, operand b and func from the slide switches.
//   - Holds the loaded values in registers that drive the calculator's a/b/func inputs.
//   - Flags when a complete operand set is presented (valid).
// PARAMETERS
//   width            6       operand width in bits; must match the calculator's width
//   DEBOUNCE_CYCLES  500000  consecutive stable cycles before a key change is accepted
//                            (10 ms at 50 MHz); must be >= 2
// PORTS
//   clk      in   1      system clock, all state on rising edge
//   rst_n    in   1      asynchronous reset, active-low
//   sw       in   width  raw slide switches, operand value
//   sw_func  in   3      raw slide switches, function select
//   key_next in   1      raw push-button, active-low: advance/commit
//   key_clr  in   1      raw push-button, active-low: clear and restart
//   a        out  width  registered operand a
//   b        out  width  registered operand b
//   func     out  3      registered function select
//   valid    out  1      1 when a, b and func are all committed (SHOW phase)
//   phase    out  2      current phase for LEDs: 0=LOAD_A 1=LOAD_B 2=LOAD_F 3=SHOW
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - a=0, b=0, func=0, valid=0, phase=LOAD_A.
//     - Synchronizer and debounced key state = 1 (released); debounce counters = 0.
//   Key conditioning, identical per key:
//     - 2-flop synchronizer on the raw input.
//     - Counter increments while the sync output differs from the debounced state.
//     - Counter clears to 0 the cycle the sync output equals the debounced state.
//     - When the counter reaches DEBOUNCE_CYCLES-1 and the input still differs,
//       the debounced state flips at the next edge and the counter clears.
//     - Press event: 1-cycle pulse on the 1->0 transition of the debounced state.
//       Release produces no event.
//     - A key held for any length produces exactly one event.
//     - Glitches shorter than DEBOUNCE_CYCLES cycles produce none.
//   Latency:
//     - Raw key sampled low and held: a/b/func/phase update at edge DEBOUNCE_CYCLES+3,
//       counted from the first edge that samples it low.
//   FSM (state == phase):
//     LOAD_A --next--> LOAD_B   a    <= sw       (value sampled on the commit edge)
//     LOAD_B --next--> LOAD_F   b    <= sw
//     LOAD_F --next--> SHOW     func <= sw_func; valid <= 1 on the same edge
//     SHOW   --next--> LOAD_A   valid <= 0; a/b/func keep their values
//     any    --clr-->  LOAD_A   a=b=func=0, valid=0
//   Output rules:
//     - No other event changes a, b or func.
//     - Switch movement while waiting is ignored until the commit edge.
//   Simultaneous next and clr events in the same cycle: clr wins, next is dropped.
//   valid equals (phase==SHOW) at all times; no combinational path from any input to any output.
//   Reset asserted mid-debounce or mid-sequence:
//     - Everything returns to reset values immediately.
//     - A key still held at reset release must be released and pressed again to generate an event.
// TESTING  (bench uses DEBOUNCE_CYCLES=4)
//   1. Reset, then idle 20 cycles
//      -> a=0, b=0, func=0, valid=0, phase=0.
//   2. sw=6'd5: press next; sw=6'h3E: press next; sw_func=3'b010: press next
//      -> a=5, b=6'h3E, func=2, valid=1, phase=3; each update exactly 7 edges after the press.
//   3. key_next pulsed low for 3 cycles (below the debounce window)
//      -> no state change; counter back to 0.
//      key_next bouncing 0/1 for 10 cycles, then held low 8 cycles
//      -> exactly one advance.
//   4. In SHOW with a=5, b=62: change sw, press next
//      -> phase=0, valid=0, a=5, b=62 unchanged.
//   5. In LOAD_F: press next and clr in the same cycle
//      -> phase=0, a=b=func=0, valid=0; func not loaded.
//   6. Hold key_next low, assert rst_n=0 mid-count, release rst_n with the key still held
//      -> no event until the key is released for >=4 cycles and pressed again.

Source files
------------

// File: rtl/operand_entry.sv
// Operand entry stage: debounces the NEXT/CLR push-buttons and walks the user
// through loading a, b and func from the slide switches for the calculator.

// One debounced push-button: 2-flop synchronizer, stability counter, press pulse.
module operand_entry_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          db_state;
  logic [CW-1:0] cnt;
  logic [1:0]    fill;
  logic          armed;
  logic [CW-1:0] arm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      fill  <= 2'b00;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      fill  <= {fill[0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_state <= 1'b1;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 == db_state) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        db_state <= sync2;
        cnt      <= '0;
        press    <= ~sync2 & armed;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // A key held through reset must first be seen released for a full debounce
  // window; fill masks the synchronizer's reset values so they cannot arm it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed   <= 1'b0;
      arm_cnt <= '0;
    end else if (!armed) begin
      if (fill[1] && sync2) begin
        if (arm_cnt == LAST) begin
          armed <= 1'b1;
        end else begin
          arm_cnt <= arm_cnt + 1'b1;
        end
      end else begin
        arm_cnt <= '0;
      end
    end
  end

endmodule

module operand_entry #(
  parameter int width           = 6,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] sw,
  input  logic [2:0]       sw_func,
  input  logic             key_next,
  input  logic             key_clr,
  output logic [width-1:0] a,
  output logic [width-1:0] b,
  output logic [2:0]       func,
  output logic             valid,
  output logic [1:0]       phase
);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    LOAD_F = 2'd2,
    SHOW   = 2'd3
  } phase_t;

  phase_t state;
  phase_t state_next;
  logic   next_ev;
  logic   clr_ev;

  operand_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_next (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_raw (key_next),
    .press   (next_ev)
  );

  operand_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clr (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_raw (key_clr),
    .press   (clr_ev)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD_A;
    end else begin
      state <= state_next;
    end
  end

  // Clear takes priority over a simultaneous next press.
  always_comb begin
    state_next = state;
    if (clr_ev) begin
      state_next = LOAD_A;
    end else if (next_ev) begin
      case (state)
        LOAD_A:  state_next = LOAD_B;
        LOAD_B:  state_next = LOAD_F;
        LOAD_F:  state_next = SHOW;
        default: state_next = LOAD_A;
      endcase
    end
  end

  always_comb begin
    phase = state;
    valid = (state == SHOW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a    <= '0;
      b    <= '0;
      func <= '0;
    end else if (clr_ev) begin
      a    <= '0;
      b    <= '0;
      func <= '0;
    end else if (next_ev) begin
      case (state)
        LOAD_A:  a    <= sw;
        LOAD_B:  b    <= sw;
        LOAD_F:  func <= sw_func;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_entry.sv
// Scoreboard bench for operand_entry with a 4-cycle debounce window:
// each press pushes the expected outputs and update cycle, the monitor pops on change.
module tb_operand_entry;

  localparam int WIDTH = 6;
  localparam int DB    = 4;
  localparam int LAT   = DB + 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [WIDTH-1:0] sw = '0;
  logic [2:0]       sw_func = '0;
  logic             key_next = 1'b1;
  logic             key_clr = 1'b1;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       func;
  logic             valid;
  logic [1:0]       phase;

  operand_entry #(.width(WIDTH), .DEBOUNCE_CYCLES(DB)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (sw),
    .sw_func  (sw_func),
    .key_next (key_next),
    .key_clr  (key_clr),
    .a        (a),
    .b        (b),
    .func     (func),
    .valid    (valid),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [17:0] val;
    int          at;
  } exp_t;
  exp_t sb[$];

  logic [WIDTH-1:0] m_a = '0;
  logic [WIDTH-1:0] m_b = '0;
  logic [2:0]       m_func = '0;
  logic [1:0]       m_phase = '0;

  logic [17:0] prev_out = '0;
  bit          mon_en = 1'b0;

  function automatic logic [17:0] pack_model();
    return {m_a, m_b, m_func, (m_phase == 2'd3), m_phase};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Called just after a falling edge; drives the keys and records what must follow.
  task automatic applyStimulus(input bit do_next, input bit do_clr, input int hold);
    exp_t e;
    if (do_clr) begin
      m_a = '0; m_b = '0; m_func = '0; m_phase = 2'd0;
    end else if (do_next) begin
      case (m_phase)
        2'd0: begin m_a = sw; m_phase = 2'd1; end
        2'd1: begin m_b = sw; m_phase = 2'd2; end
        2'd2: begin m_func = sw_func; m_phase = 2'd3; end
        default: m_phase = 2'd0;
      endcase
    end
    e.val = pack_model();
    e.at  = cyc + LAT;
    sb.push_back(e);
    key_next = ~do_next;
    key_clr  = ~do_clr;
    repeat (hold) @(negedge clk);
    key_next = 1'b1;
    key_clr  = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic [17:0] cur;
    exp_t        e;
    if (mon_en) begin
      cur = {a, b, func, valid, phase};
      if (cur !== prev_out) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_change", 32'(cur), 32'(prev_out));
        end else begin
          e = sb.pop_front();
          checkOutput("outputs", 32'(cur), 32'(e.val));
          checkOutput("latency", cyc, e.at);
        end
        prev_out = cur;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // 1. reset and idle
    repeat (20) @(negedge clk);
    checkOutput("reset_a", 32'(a), 0);
    checkOutput("reset_b", 32'(b), 0);
    checkOutput("reset_func", 32'(func), 0);
    checkOutput("reset_valid", 32'(valid), 0);
    checkOutput("reset_phase", 32'(phase), 0);

    // 2. load a full operand set
    sw = 6'd5;
    applyStimulus(1'b1, 1'b0, 8);
    sw = 6'h3E;
    applyStimulus(1'b1, 1'b0, 8);
    sw_func = 3'b010;
    applyStimulus(1'b1, 1'b0, 8);
    checkOutput("show_a", 32'(a), 5);
    checkOutput("show_b", 32'(b), 32'h3E);
    checkOutput("show_func", 32'(func), 2);
    checkOutput("show_valid", 32'(valid), 1);
    checkOutput("show_phase", 32'(phase), 3);

    // 3a. glitch shorter than the debounce window
    key_next = 1'b0;
    repeat (3) @(negedge clk);
    key_next = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("glitch_phase", 32'(phase), 3);
    checkOutput("glitch_counter", 32'(u_dut.u_key_next.cnt), 0);

    // 4. next from SHOW with switches moved
    sw = 6'h15;
    applyStimulus(1'b1, 1'b0, 8);
    checkOutput("wrap_a", 32'(a), 5);
    checkOutput("wrap_b", 32'(b), 62);
    checkOutput("wrap_valid", 32'(valid), 0);

    // 3b. bouncing key then a solid hold: one advance only
    for (int i = 0; i < 10; i++) begin
      key_next = (i % 2 == 1);
      @(negedge clk);
    end
    applyStimulus(1'b1, 1'b0, 8);
    checkOutput("bounce_phase", 32'(phase), 1);

    // 5. simultaneous next and clear in LOAD_F
    sw = 6'h2A;
    applyStimulus(1'b1, 1'b0, 8);
    sw_func = 3'b101;
    applyStimulus(1'b1, 1'b1, 8);
    checkOutput("clr_func", 32'(func), 0);
    checkOutput("clr_phase", 32'(phase), 0);

    // 6. reset while a key is held
    key_next = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("held_phase", 32'(phase), 0);
    key_next = 1'b1;
    repeat (6) @(negedge clk);
    sw = 6'h33;
    applyStimulus(1'b1, 1'b0, 8);
    checkOutput("repress_a", 32'(a), 32'h33);

    // clear on its own
    applyStimulus(1'b0, 1'b1, 8);
    checkOutput("clr_only_a", 32'(a), 0);

    repeat (5) @(negedge clk);
    checkOutput("pending_events", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
